// File: rtl/fp_pkg.sv
// Shared FPU definitions: issue-stage FSM states and IEEE754 special-value classifiers.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } fsm_t;

  // Field widths are passed in so the same helpers serve 32- and 64-bit formats.
  function automatic logic is_nan(logic [63:0] v, int unsigned ew, int unsigned mw);
    logic [63:0] mmask;
    logic [63:0] emask;
    mmask = (64'd1 << mw) - 64'd1;
    emask = ((64'd1 << ew) - 64'd1) << mw;
    return ((v & emask) == emask) && ((v & mmask) != 64'd0);
  endfunction

  function automatic logic is_inf(logic [63:0] v, int unsigned ew, int unsigned mw);
    logic [63:0] mmask;
    logic [63:0] emask;
    mmask = (64'd1 << mw) - 64'd1;
    emask = ((64'd1 << ew) - 64'd1) << mw;
    return ((v & emask) == emask) && ((v & mmask) == 64'd0);
  endfunction

endpackage

// File: rtl/fp_add_issue.sv
// Issue/retire stage around the combinational FPAdder: registers operands, waits a fixed
// settle time, captures and classifies the sum, then holds it under valid/ready.
module fp_add_issue
  import fp_pkg::*;
#(
  parameter int unsigned LOGWIDTH  = 5,
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned MANTWIDTH = 23,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ciValid,
  output logic                     doReady,
  input  logic [2**LOGWIDTH-1:0]   diA,
  input  logic [2**LOGWIDTH-1:0]   diB,
  input  logic                     ciADD_n,
  output logic [2**LOGWIDTH-1:0]   doFA,
  output logic [2**LOGWIDTH-1:0]   doFB,
  output logic                     doFADD_n,
  input  logic [2**LOGWIDTH-1:0]   diFY,
  output logic                     doValid,
  input  logic                     ciReady,
  output logic [2**LOGWIDTH-1:0]   doY,
  output logic                     doNAN,
  output logic                     doINF,
  output logic                     doBusy
);

  localparam int unsigned W    = 2**LOGWIDTH;
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  fsm_t            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    fa_q, fa_d, fb_q, fb_d, y_q, y_d;
  logic            add_n_q, add_n_d, valid_q, valid_d, nan_q, nan_d, inf_q, inf_d;
  logic            ready;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      HOLD:    ready = ciReady;
      default: ready = 1'b0;
    endcase
  end

  // Reset forces every output low, including the ready that IDLE would otherwise raise.
  assign doReady = ready & ~reset;
  assign doBusy  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    add_n_d = add_n_q;
    y_d     = y_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    valid_d = valid_q;
    if (ciValid && ready) begin
      fa_d    = diA;
      fb_d    = diB;
      add_n_d = ciADD_n;
      cnt_d   = CntW'(LATENCY - 1);
    end
    case (state_q)
      IDLE: begin
        if (ciValid) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          y_d     = diFY;
          nan_d   = is_nan(64'(diFY), EXPWIDTH, MANTWIDTH);
          inf_d   = is_inf(64'(diFY), EXPWIDTH, MANTWIDTH);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ciReady) begin
          valid_d = 1'b0;
          state_d = ciValid ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      add_n_q <= 1'b0;
      y_q     <= '0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      add_n_q <= add_n_d;
      y_q     <= y_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      valid_q <= valid_d;
    end
  end

  assign doFA     = fa_q;
  assign doFB     = fb_q;
  assign doFADD_n = add_n_q;
  assign doY      = y_q;
  assign doNAN    = nan_q;
  assign doINF    = inf_q;
  assign doValid  = valid_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Bench for fp_add_issue with a behavioural single-precision adder standing in for FPAdder.
module tb_fp_add_issue;

  localparam int unsigned LATENCY = 2;

  logic        clk, reset, ciValid, doReady, ciADD_n, doFADD_n;
  logic        doValid, ciReady, doNAN, doINF, doBusy;
  logic [31:0] diA, diB, doFA, doFB, diFY, doY;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_issue #(
    .LOGWIDTH (5),
    .EXPWIDTH (8),
    .MANTWIDTH(23),
    .LATENCY  (LATENCY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ciValid (ciValid),
    .doReady (doReady),
    .diA     (diA),
    .diB     (diB),
    .ciADD_n (ciADD_n),
    .doFA    (doFA),
    .doFB    (doFB),
    .doFADD_n(doFADD_n),
    .diFY    (diFY),
    .doValid (doValid),
    .ciReady (ciReady),
    .doY     (doY),
    .doNAN   (doNAN),
    .doINF   (doINF),
    .doBusy  (doBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_nan(logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic ref_inf(logic [31:0] v);
    return (v[30:23] == 8'hff) && (v[22:0] == 23'd0);
  endfunction

  function automatic real to_real(logic [31:0] v);
    logic [10:0] e;
    if (v[30:23] == 8'd0) return 0.0;
    e = 11'(v[30:23]) + 11'd896;
    return $bitstoreal({v[31], e, v[22:0], 29'd0});
  endfunction

  // Exact for the operand table used here; special values handled as IEEE754 requires.
  function automatic logic [31:0] fp_add_ref(logic [31:0] a, logic [31:0] b, logic sub);
    logic [31:0] bb;
    logic [63:0] d;
    logic [10:0] e;
    real         r;
    bb = b ^ {sub, 31'd0};
    if (ref_nan(a) || ref_nan(bb)) return 32'h7fc00000;
    if (ref_inf(a) && ref_inf(bb)) return (a[31] == bb[31]) ? a : 32'h7fc00000;
    if (ref_inf(a)) return a;
    if (ref_inf(bb)) return bb;
    r = to_real(a) + to_real(bb);
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign diFY = fp_add_ref(doFA, doFB, doFADD_n);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  logic [31:0] op_tab [11];
  initial begin
    op_tab = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3f000000,
               32'hc0a00000, 32'h41200000, 32'h00000000, 32'h7f800000, 32'hff800000,
               32'h7fc00000};
  end

  function automatic logic [31:0] rand_op();
    return op_tab[$urandom_range(0, 10)];
  endfunction

  // One isolated transaction from IDLE, holding the result for `hold` cycles before retire.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] exp_y, input int hold);
    int          cyc;
    logic [31:0] y_seen;
    @(negedge clk);
    check_eq("ready_idle", 32'(doReady), 32'd1);
    diA = a; diB = b; ciADD_n = sub; ciValid = 1'b1; ciReady = 1'b0;
    @(negedge clk);
    ciValid = 1'b0;
    check_eq("busy_exec", 32'(doBusy), 32'd1);
    check_eq("op_a_reg", doFA, a);
    cyc = 0;
    while (!doValid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(LATENCY));
    check_eq("result", doY, exp_y);
    check_eq("nan_flag", 32'(doNAN), 32'(ref_nan(exp_y)));
    check_eq("inf_flag", 32'(doINF), 32'(ref_inf(exp_y)));
    y_seen = doY;
    for (int i = 0; i < hold; i++) begin
      diA = rand_op(); ciValid = 1'b1;
      check_eq("hold_ready", 32'(doReady), 32'd0);
      @(negedge clk);
      check_eq("hold_valid", 32'(doValid), 32'd1);
      check_eq("hold_y", doY, y_seen);
    end
    ciValid = 1'b0;
    ciReady = 1'b1;
    #1 check_eq("ready_pass", 32'(doReady), 32'd1);
    @(negedge clk);
    ciReady = 1'b0;
    check_eq("retired_valid", 32'(doValid), 32'd0);
    check_eq("retired_busy", 32'(doBusy), 32'd0);
    check_eq("retired_y_kept", doY, y_seen);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] exp_y;
    logic [31:0] a, b;
    logic        s;
    int          n_acc, n_ret, last_ret;
    bit          load_next;

    reset = 1'b1; ciValid = 1'b0; ciReady = 1'b0; ciADD_n = 1'b0;
    diA = '0; diB = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(doValid), 32'd0);
    check_eq("rst_busy", 32'(doBusy), 32'd0);
    check_eq("rst_y", doY, 32'd0);
    check_eq("rst_fa", doFA, 32'd0);
    reset = 1'b0;

    run_op(32'h3f800000, 32'h40000000, 1'b0, 32'h40400000, 0);
    run_op(32'h40400000, 32'h3f800000, 1'b1, 32'h40000000, 5);
    run_op(32'h7f800000, 32'h3f800000, 1'b0, 32'h7f800000, 1);
    run_op(32'h7fc00000, 32'h3f800000, 1'b0, 32'h7fc00000, 0);

    for (int k = 0; k < 12; k++) begin
      a = rand_op(); b = rand_op(); s = 1'($urandom_range(0, 1));
      run_op(a, b, s, fp_add_ref(a, b, s), int'($urandom_range(0, 3)));
    end

    // Back-to-back: valid and ready held high; retire and accept share an edge.
    n_acc = 0; n_ret = 0; last_ret = -1; load_next = 1'b1;
    ciReady = 1'b1;
    for (int cyc = 0; cyc < 60 && n_ret < 8; cyc++) begin
      @(negedge clk);
      if (load_next) begin
        load_next = 1'b0;
        if (n_acc < 8) begin
          diA = rand_op(); diB = rand_op(); ciADD_n = 1'($urandom_range(0, 1));
          ciValid = 1'b1;
        end else begin
          ciValid = 1'b0;
        end
      end
      if (doValid) begin
        exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdeadbeef;
        check_eq("b2b_result", doY, exp_y);
        if (last_ret >= 0) check_eq("b2b_period", 32'(cyc - last_ret), 32'(LATENCY + 1));
        last_ret = cyc;
        n_ret++;
      end
      if (doReady && ciValid) begin
        exp_q.push_back(fp_add_ref(diA, diB, ciADD_n));
        n_acc++;
        load_next = 1'b1;
      end
    end
    check_eq("b2b_count", 32'(n_ret), 32'd8);
    check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);
    ciValid = 1'b0; ciReady = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of EXEC.
    diA = 32'h41200000; diB = 32'h40000000; ciADD_n = 1'b0; ciValid = 1'b1;
    @(negedge clk);
    ciValid = 1'b0;
    check_eq("pre_rst_busy", 32'(doBusy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", 32'(doBusy), 32'd0);
    check_eq("arst_valid", 32'(doValid), 32'd0);
    check_eq("arst_y", doY, 32'd0);
    check_eq("arst_fa", doFA, 32'd0);
    check_eq("arst_ready", 32'(doReady), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("post_rst_ready", 32'(doReady), 32'd1);
    run_op(32'h3f800000, 32'h40000000, 1'b0, 32'h40400000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
